// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding and geometry for the data cache controller
package dcache_pkg;

  localparam int OFFSET_W   = 5;
  localparam int LINE_W     = 256;
  localparam int WORD_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH,
    REFILL
  } dcache_state_e;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage, combinational read, synchronous write
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 27 - IDX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic                  line_we,
  input  logic [IDX_W-1:0]      line_idx,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_W-1:0]     line_data,
  input  logic                  word_we,
  input  logic [IDX_W-1:0]      word_idx,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [31:0]           word_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Only the state bits are reset; tag and data are meaningless while invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[line_idx] <= 1'b1;
      dirty_q[line_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[word_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end else if (word_we) begin
      data_q[word_idx][word_sel*32 +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// DCACHE_STATS_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
`endif
  input  logic              mem_ack_i
);

  localparam int TAG_W = 27 - IDX_W;

  dcache_state_e state_q, state_d;

  logic [WORD_SEL_W-1:0] req_word;
  logic [IDX_W-1:0]      req_idx, miss_idx_q, rd_idx;
  logic [TAG_W-1:0]      req_tag, miss_tag_q, rd_tag;
  logic                  rd_valid, rd_dirty;
  logic [LINE_W-1:0]     rd_line, fill_q;
  logic                  hit, miss;
  logic                  line_we, word_we;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign req_word = cpu_addr_i[OFFSET_W-1:2];
  assign req_idx  = cpu_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
  assign req_tag  = cpu_addr_i[31:OFFSET_W+IDX_W];

  // Outside IDLE the array is steered to the latched miss line so the victim
  // and refill stay correct even if the request drops mid-miss.
  assign rd_idx = (state_q == IDLE) ? req_idx : miss_idx_q;
  assign hit    = cpu_req_i && rd_valid && (rd_tag == req_tag);
  assign miss   = (state_q == IDLE) && cpu_req_i && !hit;

  dcache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_idx  (miss_idx_q),
    .line_tag  (miss_tag_q),
    .line_data (fill_q),
    .word_we   (word_we),
    .word_idx  (req_idx),
    .word_sel  (req_word),
    .word_data (cpu_data_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = (rd_valid && rd_dirty) ? WB : FETCH;
      WB:      if (mem_ack_i) state_d = FETCH;
      FETCH:   if (mem_ack_i) state_d = REFILL;
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b1;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_stall_o = miss;
        word_we     = hit && cpu_we_i;
        if (hit && !cpu_we_i) cpu_data_o = rd_line[req_word*32 +: 32];
      end
      WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, miss_idx_q, {OFFSET_W{1'b0}}};
        mem_data_o   = rd_line;
      end
      FETCH: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
      end
      REFILL: begin
        line_we = 1'b1;
      end
      default: begin
        cpu_stall_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      fill_q     <= '0;
    end else begin
      if (miss) begin
        miss_idx_q <= req_idx;
        miss_tag_q <= req_tag;
      end
      if (state_q == FETCH && mem_ack_i) fill_q <= mem_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_refill_q;

  // The hit that retires a miss is not a separate access, so it is not counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o      <= '0;
      miss_cnt_o     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      after_refill_q <= (state_q == REFILL);
      if (miss && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state_q == IDLE && hit && !after_refill_q && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a line-level cache/memory model
module tb_dcache_ctrl;

  localparam int IDX_W = 4;
  localparam int TAG_W = 27 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.IDX_W(IDX_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
`endif
    .mem_ack_i    (mem_ack_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cache contents per line plus a sparse backing memory.
  logic               m_valid [LINES];
  logic               m_dirty [LINES];
  logic [TAG_W-1:0]   m_tag   [LINES];
  logic [255:0]       m_line  [LINES];
  logic [255:0]       mem_q   [logic [31:0]];

  logic [31:0]  last_wb_addr, last_fetch_addr;
  logic [255:0] last_wb_line;

  function automatic logic [255:0] mem_read(input logic [31:0] a);
    logic [255:0] l;
    if (!mem_q.exists(a)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      mem_q[a] = l;
    end
    return mem_q[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int kwb, input int kf);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      line_addr, wb_addr, exp_rd;
    logic [255:0]     new_line, junk;
    int               w, exp_stall, stall_n, ph, wb_n, fetch_n;
    bit               exp_hit, exp_wb, done;
    idx       = addr[4+IDX_W:5];
    tag       = addr[31:5+IDX_W];
    w         = int'(addr[4:2]);
    line_addr = {addr[31:5], 5'b0};
    exp_hit   = m_valid[idx] && (m_tag[idx] == tag);
    exp_wb    = !exp_hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], idx, 5'b0};
    new_line  = exp_hit ? m_line[idx] : mem_read(line_addr);
    exp_rd    = new_line[w*32 +: 32];
    exp_stall = exp_hit ? 0 : 2 + kf + (exp_wb ? kwb : 0);
    stall_n = 0; ph = 0; wb_n = 0; fetch_n = 0; done = 0;

    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (!cpu_stall_o) begin
        done = 1;
        if (we) check("store_data_o", cpu_data_o, 0);
        else    check("load_data", cpu_data_o, exp_rd);
        check("mem_en_no_stall", mem_enable_o, 0);
      end else begin
        stall_n++;
        if (mem_enable_o) begin
          ph++;
          if (mem_write_o) begin
            if (ph == 1) begin
              wb_n++;
              last_wb_addr = mem_addr_o;
              last_wb_line = mem_data_o;
              check("wb_addr", mem_addr_o, wb_addr);
              check("wb_line", mem_data_o, m_line[idx]);
            end
            if (ph == kwb) begin
              mem_ack_i = 1'b1;
              mem_q[wb_addr] = m_line[idx];
              ph = 0;
            end
          end else begin
            if (ph == 1) begin
              fetch_n++;
              last_fetch_addr = mem_addr_o;
              check("fetch_addr", mem_addr_o, line_addr);
            end
            if (ph == kf) begin
              mem_ack_i  = 1'b1;
              mem_data_i = new_line;
              ph = 0;
            end
          end
        end
      end
      if (!done) begin
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        for (int i = 0; i < 8; i++) junk[i*32 +: 32] = $urandom;
        mem_data_i = junk;
      end
    end
    mem_ack_i = 1'b0;
    check("access_done", done, 1);
    check("stall_cycles", stall_n, exp_stall);
    check("wb_count", wb_n, exp_wb);
    check("fetch_count", fetch_n, !exp_hit);

    m_valid[idx] = 1'b1;
    m_tag[idx]   = tag;
    m_line[idx]  = new_line;
    if (!exp_hit) m_dirty[idx] = 1'b0;
    if (we) begin
      m_line[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    check("idle_stall", cpu_stall_o, 0);
    check("idle_data", cpu_data_o, 0);
  endtask

  logic [255:0] l40;
  logic [31:0]  raddr;
  bit           seen;

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) l40[i*32 +: 32] = 32'h1000_0000 + i;
    l40[63:32] = 32'hDEADBEEF;
    l40[95:64] = 32'h0000CAFE;
    mem_q[32'h40] = l40;

    #1;
    check("rst_stall", cpu_stall_o, 0);
    check("rst_data", cpu_data_o, 0);
    check("rst_mem_en", mem_enable_o, 0);
    check("rst_mem_wr", mem_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    do_access(1'b0, 32'h44, 32'h0, 1, 3);
    check("t1_fetch_addr", last_fetch_addr, 32'h40);
    do_access(1'b0, 32'h48, 32'h0, 1, 1);
    do_access(1'b1, 32'h44, 32'h12345678, 1, 1);
    do_access(1'b0, 32'h244, 32'h0, 2, 2);
    check("t3_wb_addr", last_wb_addr, 32'h40);
    check("t3_wb_word1", last_wb_line[63:32], 32'h12345678);
    check("t3_fetch_addr", last_fetch_addr, 32'h240);
`ifdef DCACHE_STATS_EN
    #1;
    check("hit_cnt", hit_cnt_o, 2);
    check("miss_cnt", miss_cnt_o, 2);
`endif

    do_access(1'b1, 32'h100, 32'hA5A5A5A5, 1, 1);
    check("t4_fetch_addr", last_fetch_addr, 32'h100);
    do_access(1'b0, 32'h300, 32'h0, 3, 1);
    check("t4_wb_addr", last_wb_addr, 32'h100);
    check("t4_wb_word0", last_wb_line[31:0], 32'hA5A5A5A5);
    do_access(1'b0, 32'h100, 32'h0, 1, 2);

    // Reset in the middle of a line fill.
    do_access(1'b0, 32'h44, 32'h0, 1, 1);
    do_access(1'b0, 32'h44, 32'h0, 1, 1);
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h184;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (mem_enable_o && !mem_write_o) seen = 1;
      else @(negedge clk_i);
    end
    check("t5_reach_fetch", seen, 1);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    #1;
    check("t5_rst_mem_en", mem_enable_o, 0);
    check("t5_rst_stall", cpu_stall_o, 0);
    check("t5_rst_mem_addr", mem_addr_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    do_access(1'b0, 32'h44, 32'h0, 1, 2);
    check("t5_refetch_addr", last_fetch_addr, 32'h40);

    for (int n = 0; n < 200; n++) begin
      raddr = ($urandom_range(0, 3) << (5 + IDX_W)) | ($urandom_range(0, LINES - 1) << 5)
            | ($urandom_range(0, 7) << 2);
      do_access(1'($urandom_range(0, 1)), raddr, $urandom,
                $urandom_range(1, 4), $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    idle_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the pipelined CPU. Sits between the MEM-stage load/store path and the 256-bit off-chip data memory. Its `cpu_stall_o` is the memory stall that freezes the pipeline, including the MEM/WB register's `MemStall_i`, until a miss is serviced.

## Interface
- `IDX_W`, default 4: index bits; 2^IDX_W lines. Tag width = 27-IDX_W.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cpu_req_i` in 1: access valid (MemRead | MemWrite).
- `cpu_we_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address, word-aligned.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data.
- `cpu_stall_o` out 1: pipeline stall.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: 1 = writeback, 0 = line fetch.
- `mem_addr_o` out 32: line address, bits [4:0] = 0.
- `mem_data_o` out 256: writeback line.
- `mem_data_i` in 256: fetched line.
- `mem_ack_i` in 1: single-cycle completion pulse.

## Operation
- Address split: [1:0] ignored; [4:2] word select; [4+IDX_W:5] index; [31:5+IDX_W] tag.
- Per line: valid, dirty, tag, 256-bit data. Word w occupies data[32w+31:32w].
- Hit = `cpu_req_i` & valid & tag match.
- FSM states:
  - IDLE: on a hit, load data is combinational and a store writes the word and sets dirty at the edge. On a miss, go to WB if the victim is valid & dirty, else go to FETCH.
  - WB: enable=1, write=1, addr={victim tag, index, 5'b0}, data=victim line. On ack, go to FETCH.
  - FETCH: enable=1, write=0, addr={req tag, index, 5'b0}. On ack, capture `mem_data_i` and go to REFILL.
  - REFILL: write line, valid=1, dirty=0, tag=req tag. Go to IDLE, where the retried access hits; a store then sets dirty.
- `cpu_stall_o` = (IDLE & req & ~hit) | (state != IDLE). Combinational.
- `cpu_data_o` = selected word on a load hit, else 0.
- `mem_*` outputs are 0 in IDLE and REFILL. Enable is held until ack. An ack outside WB/FETCH is ignored.
- The pipeline holds `cpu_*` stable while stalled. If `cpu_req_i` drops mid-miss, the transaction still completes the line fill.
- Reset (async, any state): FSM to IDLE, all valid/dirty cleared, `mem_*` = 0. Dirty data is discarded.

## Timing
- Hit: zero added latency. Store commits at the next edge.
- Clean miss with ack in the K-th FETCH cycle: stall = 1 (detect) + K + 1 (REFILL) cycles. Data is valid with stall=0 in the following cycle.
- Dirty miss: add the WB cycles up to and including the WB ack.
- Reset values: `cpu_stall_o`=0 (req low), `cpu_data_o`=0, `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_cnt_o` and `miss_cnt_o`, 32 bits each, reset to 0, saturating at 0xFFFFFFFF.
  - Miss increments on IDLE miss detection.
  - Hit increments on an IDLE hit that does not immediately follow REFILL.
- Undefined: no counters and no ports.

## Structure
- Package `dcache_pkg`: state enum (IDLE, WB, FETCH, REFILL), `OFFSET_W`=5, `LINE_W`=256, `WORD_SEL_W`=3.
- Sub-module `dcache_array`: tag/valid/dirty/data storage. Read is combinational, write is synchronous, and valid/dirty are async-cleared on `rst_i`.

## Test plan
1. Reset, then load 0x44. Expect a FETCH at 0x40. Ack on the 3rd cycle with word1=0xDEADBEEF. Expect stall=5 cycles, then `cpu_data_o`=0xDEADBEEF.
2. Load 0x48 (word2=0x0000CAFE). Expect stall=0 and data 0x0000CAFE.
3. Store 0x12345678 to 0x44: no stall. Then load 0x244 (same index 2). Expect WB at 0x40 with word1=0x12345678, then FETCH at 0x240.
4. Clean store miss to 0x100 with data 0xA5A5A5A5. Expect FETCH at 0x100, then the line updates and is dirty. A later conflicting access to 0x300 writes back 0xA5A5A5A5 at 0x100.
5. Assert `rst_i` during FETCH. Expect `mem_enable_o` and stall to go 0 immediately; a later load 0x44 misses again.
6. With `DCACHE_STATS_EN`, running scenarios 1–3 gives `hit_cnt_o`=2 and `miss_cnt_o`=2.
